// File: rtl/pq_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// pq_cmd_driver_if
// Bundles the three channels around pq_cmd_driver:
//   command channel  : i_cmd_valid / o_cmd_ready / i_cmd_op / i_cmd_data
//   response channel : o_rsp_valid / i_rsp_ready / o_rsp_data / o_rsp_status
//   queue port       : o_pq_wrt / o_pq_read / o_pq_data (to queue)
//                      i_pq_full / i_pq_empty / i_pq_data (from queue)
//   debug            : o_dbg_state (driver FSM state, for checkers)
// Names keep the driver's point of view (i_ = into the driver).
//
// Handshake rule for both valid/ready channels: a transfer happens on the
// rising clock edge where valid and ready are both high. Once valid is
// raised, the payload stays stable and valid stays high until that edge.
//
// Modports:
//   slave  - the driver itself
//   master - the environment (upstream logic plus the attached queue)
// ---------------------------------------------------------------------------
interface pq_cmd_driver_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [1:0]            i_cmd_op;
  logic [DATA_WIDTH-1:0] i_cmd_data;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic [1:0]            o_rsp_status;

  logic                  o_pq_wrt;
  logic                  o_pq_read;
  logic [DATA_WIDTH-1:0] o_pq_data;
  logic                  i_pq_full;
  logic                  i_pq_empty;
  logic [DATA_WIDTH-1:0] i_pq_data;

  logic [1:0]            o_dbg_state;

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_data,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_data, o_rsp_status,
    input  i_rsp_ready,
    output o_pq_wrt, o_pq_read, o_pq_data,
    input  i_pq_full, i_pq_empty, i_pq_data,
    output o_dbg_state
  );

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_data,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_data, o_rsp_status,
    output i_rsp_ready,
    input  o_pq_wrt, o_pq_read, o_pq_data,
    output i_pq_full, i_pq_empty, i_pq_data,
    input  o_dbg_state
  );
endinterface

// File: rtl/pq_cmd_driver.sv
// ---------------------------------------------------------------------------
// pq_cmd_driver
// Initiator-side sequencer for the register-tree priority queue. Takes one
// ENQ / DEQ / REPLACE command at a time, pulses the queue for one cycle,
// waits out the queue's settle latency and returns one response (popped key
// plus status) per command.
//
// Ports:
//   i_CLK   - clock
//   i_RSTn  - asynchronous active-low reset
//   bus     - pq_cmd_driver_if.slave (command, response, queue, debug)
//
// Status codes: 0=OK, 1=SKIP_FULL, 2=SKIP_EMPTY, 3=ILLEGAL.
// Op codes:     0=ENQ, 1=DEQ, 2=REPLACE, 3=reserved.
// ---------------------------------------------------------------------------
module pq_cmd_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 15,
  parameter int ENQ_WAIT   = $clog2(QUEUE_SIZE),
  parameter int DEQ_WAIT   = 2,
  parameter bit ENQ_ENA    = 1'b1
) (
  input  logic            i_CLK,
  input  logic            i_RSTn,
  pq_cmd_driver_if.slave  bus
);

  localparam logic [1:0] OP_ENQ  = 2'd0;
  localparam logic [1:0] OP_DEQ  = 2'd1;
  localparam logic [1:0] OP_REPL = 2'd2;
  localparam logic [1:0] OP_RSV  = 2'd3;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_SKIP_FULL  = 2'd1;
  localparam logic [1:0] ST_SKIP_EMPTY = 2'd2;
  localparam logic [1:0] ST_ILLEGAL    = 2'd3;

  localparam int MAX_WAIT = (ENQ_WAIT > DEQ_WAIT) ? ENQ_WAIT : DEQ_WAIT;
  localparam int CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q,      state_d;
  logic [1:0]            op_q,         op_d;
  logic                  empty_q,      empty_d;
  logic [CW-1:0]         cnt_q,        cnt_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,   rsp_data_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic                  pq_wrt_q,     pq_wrt_d;
  logic                  pq_read_q,    pq_read_d;
  logic [DATA_WIDTH-1:0] pq_data_q,    pq_data_d;

  logic cmd_ready;
  logic accept;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = bus.i_cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    empty_d      = empty_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    pq_wrt_d     = 1'b0;
    pq_read_d    = 1'b0;
    pq_data_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = bus.i_cmd_op;
          empty_d    = bus.i_pq_empty;
          rsp_data_d = '0;
          state_d    = S_ISSUE;
          // Rejected commands still pass through ISSUE (without a pulse)
          // so every response appears at least one cycle after accept.
          if ((bus.i_cmd_op == OP_ENQ && !ENQ_ENA) || bus.i_cmd_op == OP_RSV) begin
            rsp_status_d = ST_ILLEGAL;
          end else if (bus.i_cmd_op == OP_ENQ && bus.i_pq_full) begin
            rsp_status_d = ST_SKIP_FULL;
          end else if (bus.i_cmd_op == OP_DEQ && bus.i_pq_empty) begin
            rsp_status_d = ST_SKIP_EMPTY;
          end else begin
            rsp_status_d = ST_OK;
            pq_wrt_d     = (bus.i_cmd_op != OP_DEQ);
            pq_read_d    = (bus.i_cmd_op != OP_ENQ);
            pq_data_d    = (bus.i_cmd_op == OP_DEQ) ? '0 : bus.i_cmd_data;
          end
        end
      end

      S_ISSUE: begin
        if (rsp_status_q != ST_OK) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          // Queue output still shows the pre-operation top at this edge.
          // REPLACE on an empty queue is a pure insert: nothing popped.
          if ((op_q == OP_DEQ || op_q == OP_REPL) && !empty_q) begin
            rsp_data_d = bus.i_pq_data;
          end else begin
            rsp_data_d = '0;
          end
          if (((op_q == OP_ENQ) ? ENQ_WAIT : DEQ_WAIT) == 0) begin
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            cnt_d   = (op_q == OP_ENQ) ? CW'(ENQ_WAIT) : CW'(DEQ_WAIT);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Leaving on the cycle the count would hit zero makes the response
        // rise exactly WAIT edges after the ISSUE edge.
        if (cnt_q <= CW'(1)) begin
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q      <= S_IDLE;
      op_q         <= 2'd0;
      empty_q      <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'd0;
      pq_wrt_q     <= 1'b0;
      pq_read_q    <= 1'b0;
      pq_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      empty_q      <= empty_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      pq_wrt_q     <= pq_wrt_d;
      pq_read_q    <= pq_read_d;
      pq_data_q    <= pq_data_d;
    end
  end

  // Ready is the only combinational output; gate it with reset so it is
  // low for the whole reset pulse.
  assign bus.o_cmd_ready  = cmd_ready && i_RSTn;
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_data   = rsp_data_q;
  assign bus.o_rsp_status = rsp_status_q;
  assign bus.o_pq_wrt     = pq_wrt_q;
  assign bus.o_pq_read    = pq_read_q;
  assign bus.o_pq_data    = pq_data_q;
  assign bus.o_dbg_state  = state_q;

endmodule

// File: doc/pq_cmd_driver.md
Name: pq_cmd_driver

Overview:
- Initiator-side sequencer for the register-tree priority-queue port (i_wrt / i_read / i_data, o_full / o_empty / o_data).
- Accepts enqueue, dequeue and replace commands from upstream over a valid/ready channel.
- Issues each command to the queue as a single-cycle pulse, then holds off for the queue's settle latency.
- Returns one response per command (popped value plus status) over a second valid/ready channel, so upstream logic never has to know the queue's pipeline timing.

Parameters:
- DATA_WIDTH, 16: key width on both channels.
- QUEUE_SIZE, 15: capacity of the attached queue; used only to derive ENQ_WAIT.
- ENQ_WAIT, $clog2(QUEUE_SIZE) (=4): idle cycles after an enqueue pulse.
- DEQ_WAIT, 2: idle cycles after a dequeue or replace pulse.
- ENQ_ENA, 1'b1: when 0, the attached queue has no enqueue path and enqueue commands are rejected.

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  driver can accept a command
- i_cmd_op  in  2  0=ENQ, 1=DEQ, 2=REPLACE, 3=reserved
- i_cmd_data  in  DATA_WIDTH  key for ENQ/REPLACE
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  upstream accepts response
- o_rsp_data  out  DATA_WIDTH  popped key (DEQ/REPLACE), else 0
- o_rsp_status  out  2  0=OK, 1=SKIP_FULL, 2=SKIP_EMPTY, 3=ILLEGAL
- o_pq_wrt  out  1  to queue i_wrt
- o_pq_read  out  1  to queue i_read
- o_pq_data  out  DATA_WIDTH  to queue i_data
- i_pq_full  in  1  from queue o_full
- i_pq_empty  in  1  from queue o_empty
- i_pq_data  in  DATA_WIDTH  from queue o_data (current top)

Behaviour:
- Reset (async, any state): FSM=IDLE, wait counter=0, all outputs 0 (o_cmd_ready=0 while i_RSTn low). Any in-flight command or response is dropped; no queue pulse is issued after reset releases.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except o_cmd_ready, which equals (state==IDLE).
- IDLE: on i_cmd_valid & o_cmd_ready at edge t, latch op and data, and classify against i_pq_full / i_pq_empty sampled at that edge:
  - ENQ with ENQ_ENA=0, or op=3: status ILLEGAL -> RESP.
  - ENQ with full: status SKIP_FULL -> RESP.
  - DEQ with empty: status SKIP_EMPTY -> RESP.
  - REPLACE with empty: legal; behaves as an insert, rsp_data=0, status OK.
  - Otherwise -> ISSUE.
  - Skipped commands: o_rsp_valid high from edge t+1, rsp_data=0, no queue pulse.
- ISSUE (exactly one cycle, t..t+1):
  - ENQ: o_pq_wrt=1, o_pq_read=0.
  - DEQ: o_pq_wrt=0, o_pq_read=1.
  - REPLACE: o_pq_wrt=1, o_pq_read=1.
  - o_pq_data=latched key for ENQ/REPLACE, 0 for DEQ.
  - At edge t+1, capture i_pq_data (pre-operation top) as rsp_data for DEQ/REPLACE on a non-empty queue; 0 for ENQ. Load counter with ENQ_WAIT (ENQ) or DEQ_WAIT (DEQ/REPLACE), then -> WAIT.
- WAIT: all o_pq_* are 0. Counter decrements once per cycle; on reaching 0 -> RESP. o_rsp_valid first rises at edge t+1+ENQ_WAIT (ENQ) or edge t+1+DEQ_WAIT (DEQ/REPLACE).
- RESP: o_rsp_valid=1; o_rsp_data and o_rsp_status are stable until i_rsp_ready. The response is consumed on the edge where valid & ready; -> IDLE, o_rsp_valid=0. A new command can be accepted at the next edge, never on the same edge.
- Only one command is outstanding at a time; the queue never sees back-to-back pulses closer than the wait interval.
- i_cmd_* are ignored outside IDLE. i_pq_full / i_pq_empty are only sampled in IDLE.

Test Plan:
- Reset, then 15 ENQ of keys 1..15, rsp_ready tied 1 -> each response OK with data 0, o_rsp_valid 5 cycles after accept, o_pq_wrt high exactly one cycle per command; i_pq_full high afterwards. A 16th ENQ of 99 -> SKIP_FULL 1 cycle after accept, no o_pq_wrt pulse.
- With the queue holding 15..1: DEQ x3 -> rsp_data 15, 14, 13, status OK, response 3 cycles after accept, one o_pq_read pulse each.
- REPLACE key 50 on a queue with top 12 -> rsp_data 12, OK, o_pq_wrt and o_pq_read high together for one cycle; following DEQ returns 50.
- Empty queue: DEQ -> SKIP_EMPTY, data 0, no pulse. REPLACE 7 -> OK, data 0; next DEQ returns 7.
- ENQ_ENA=0 instance: ENQ 5 -> ILLEGAL, no pulse. op=3 -> ILLEGAL on either instance.
- Hold i_rsp_ready=0 for 6 cycles in RESP -> o_rsp_valid/data/status stable and o_cmd_ready=0 throughout. Separately, assert i_RSTn low during WAIT -> all outputs 0 immediately; after release, o_cmd_ready=1 and no stale response appears.
